// File: rtl/pipelined_wallace_multiplier.sv
// Pipelined Wallace-tree multiplier with a valid/ready stream interface.
// Both operands are extended to WIDTH+1 bits, signed or unsigned as chosen
// by mode. Partial products are reduced by rows of 3:2 compressors spread
// over the first STAGES-1 registers. A final carry-propagate add feeds the
// output register.
module pipelined_wallace_multiplier #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 3,
  parameter int TAG_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [1:0]         mode,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int PW = 2 * WIDTH;   // working width; only the low 2*WIDTH bits are kept
  localparam int NR = WIDTH + 2;   // WIDTH AND rows, negated extension row, its +1 row
  localparam int NB = STAGES - 1;  // register boundaries that carry compressor levels
  localparam int RB = NR * PW;

  typedef logic [NR-1:0][PW-1:0] rows_t;

  // Row count after lvl compressor levels: every group of three rows becomes two.
  function automatic int rows_after(int lvl);
    int n;
    n = NR;
    for (int i = 0; i < lvl; i++) n = 2 * (n / 3) + n % 3;
    return n;
  endfunction

  function automatic int count_levels();
    int n;
    int l;
    n = NR;
    l = 0;
    while (n > 2) begin
      n = 2 * (n / 3) + n % 3;
      l++;
    end
    return l;
  endfunction

  localparam int NLVL = count_levels();

  // Partial products modulo 2^PW. Row j adds b[j]*a_ext<<j. The extension bit
  // of b weighs -2^WIDTH, so it adds the two's complement of a_ext<<WIDTH: an
  // inverted row plus a +1 row.
  function automatic rows_t build_pp(logic [WIDTH-1:0] x, logic [WIDTH-1:0] y,
                                     logic [1:0] m);
    rows_t         r;
    logic [PW-1:0] xs;
    logic          ex;
    logic          ey;
    // NOTE: function locals are plain temporaries evaluated in order, so
    // blocking assignments are correct here; registers below use <= only.
    ex = m[0] & x[WIDTH-1];
    ey = m[1] & y[WIDTH-1];
    xs = {{WIDTH{ex}}, x};
    r  = '0;
    for (int j = 0; j < WIDTH; j++) r[j] = {PW{y[j]}} & (xs << j);
    r[WIDTH]   = {PW{ey}} & ~(xs << WIDTH);
    r[WIDTH+1] = PW'(ey);
    return r;
  endfunction

  // One 3:2 level on the first n rows. The carry row moves one column left,
  // so column 0's carry lands in column 1. Leftover rows pass straight through.
  function automatic rows_t csa_level(rows_t r, int n);
    rows_t o;
    int    g;
    o = '0;
    g = n / 3;
    for (int i = 0; i < NR / 3; i++) begin
      if (i < g) begin
        o[2*i]   = r[3*i] ^ r[3*i+1] ^ r[3*i+2];
        o[2*i+1] = ((r[3*i] & r[3*i+1]) | (r[3*i] & r[3*i+2]) |
                    (r[3*i+1] & r[3*i+2])) << 1;
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (k < n % 3) o[2*g+k] = r[3*g+k];
    end
    return o;
  endfunction

  // Apply the compressor levels lo..hi-1 in order.
  function automatic rows_t reduce(rows_t r, int lo, int hi);
    rows_t t;
    t = r;
    for (int l = 0; l < NLVL; l++) begin
      if (l >= lo && l < hi) t = csa_level(t, rows_after(l));
    end
    return t;
  endfunction

  logic [STAGES-1:0] vld_q;
  logic [TAG_W-1:0]  tag_q [STAGES];
  logic [PW-1:0]     prod_q;
  logic              stall;
  logic              adv;

  assign out_valid = vld_q[STAGES-1];
  assign stall     = out_valid && !out_ready;
  assign adv       = !stall;
  assign in_ready  = adv && !flush;
  assign product   = out_valid ? prod_q : '0;
  assign out_tag   = out_valid ? tag_q[STAGES-1] : '0;

  // Compressor slices. Each one keeps only the rows still live after its levels.
  for (genvar s = 0; s < NB; s++) begin : g_slice
    localparam int LO = s * NLVL / NB;
    localparam int HI = (s + 1) * NLVL / NB;
    localparam int NQ = rows_after(HI);
    localparam int QB = NQ * PW;
    rows_t                 src;
    logic [NQ-1:0][PW-1:0] q;
    if (s == 0) begin : g_src
      assign src = build_pp(a, b, mode);
    end else begin : g_src
      assign src = RB'(g_slice[s-1].q);
    end
    // Slice register: loads the reduced rows whenever the pipe advances.
    always_ff @(posedge clk) begin
      if (adv) q <= QB'(reduce(src, LO, HI));
    end
  end

  // Valid bits: flush beats stall; otherwise they shift when the pipe advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else if (flush) begin
      vld_q <= '0;
    end else if (adv) begin
      vld_q <= {vld_q[STAGES-2:0], in_valid};
    end
  end

  // Tag pipe and final carry-propagate add into the output register.
  // NOTE: payload registers deliberately have no reset; the valid bits
  // qualify them, and the output mask hides them while out_valid is low.
  always_ff @(posedge clk) begin
    if (adv) begin
      tag_q[0] <= in_tag;
      for (int s = 1; s < STAGES; s++) tag_q[s] <= tag_q[s-1];
      prod_q <= g_slice[NB-1].q[0] + g_slice[NB-1].q[1];
    end
  end

endmodule

// File: tb/tb_pipelined_wallace_multiplier.sv
// Self-checking bench for pipelined_wallace_multiplier. The main instance
// (WIDTH=32, STAGES=3) runs directed corners, latency, backpressure, flush
// and async-reset sequences plus a random burst. Three extra instances run
// random traffic against a behavioural product model.
module tb_pipelined_wallace_multiplier;

  typedef struct {
    logic [3:0]   tag;
    logic [127:0] prod;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        rst_x;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  mode;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] product;
  logic [3:0]  out_tag;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  exp_t exp_q[$];

  pipelined_wallace_multiplier #(.WIDTH(32), .STAGES(3), .TAG_W(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .out_tag   (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string name, logic [127:0] got, logic [127:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, expv);
    end
  endtask

  // Exact (w+1)x(w+1) product, truncated to 2w bits.
  function automatic logic [127:0] ref_mul(logic [63:0] x, logic [63:0] y, int w,
                                           logic [1:0] m);
    logic signed [131:0] xe;
    logic signed [131:0] ye;
    logic signed [131:0] p;
    logic [127:0]        r;
    xe = '0;
    ye = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < w) begin
        xe[i] = x[i];
        ye[i] = y[i];
      end
    end
    for (int i = 0; i < 132; i++) begin
      if (i >= w) begin
        xe[i] = m[0] & x[w-1];
        ye[i] = m[1] & y[w-1];
      end
    end
    p = xe * ye;
    r = p[127:0];
    for (int i = 0; i < 128; i++) if (i >= 2 * w) r[i] = 1'b0;
    return r;
  endfunction

  function automatic logic [31:0] pick32();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'h0;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'h8000_0000;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  task automatic drive_op(logic [31:0] x, logic [31:0] y, logic [1:0] m, logic [3:0] t);
    a        = x;
    b        = y;
    mode     = m;
    in_tag   = t;
    in_valid = 1'b1;
  endtask

  // One clock of the main instance with scoreboarding of both handshakes.
  task automatic cycle();
    exp_t e;
    #1;
    if (out_valid && out_ready) begin
      check("out_expected", 128'(exp_q.size() != 0), 128'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_tag", 128'(out_tag), 128'(e.tag));
        check("sb_product", 128'(product), e.prod);
      end
    end
    if (in_valid && in_ready) begin
      e.tag  = in_tag;
      e.prod = ref_mul(64'(a), 64'(b), 32, mode);
      exp_q.push_back(e);
    end
    if (flush) exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  // Issue one op and check it appears exactly STAGES-1 edges after acceptance.
  task automatic corner(string name, logic [31:0] x, logic [31:0] y, logic [1:0] m,
                        logic [3:0] t, logic [63:0] expv);
    drive_op(x, y, m, t);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check({name, "_early"}, 128'(out_valid), 128'(0));
    @(posedge clk);
    #1;
    check({name, "_valid"}, 128'(out_valid), 128'(1));
    check({name, "_tag"}, 128'(out_tag), 128'(t));
    check({name, "_product"}, 128'(product), 128'(expv));
  endtask

  initial begin
    rst_n = 1'b0; rst_x = 1'b0; flush = 1'b0; in_valid = 1'b0;
    a = '0; b = '0; mode = '0; in_tag = '0; out_ready = 1'b1;
    #3;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_product", 128'(product), 128'(0));
    check("rst_out_tag", 128'(out_tag), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rst_x = 1'b1;
    @(posedge clk);
    #1;

    // Mode corners and small mixed-sign vectors.
    corner("m3_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd3, 4'd1, 64'h0000_0000_0000_0001);
    corner("m0_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd0, 4'd2, 64'hFFFF_FFFE_0000_0001);
    corner("m1_min",  32'h8000_0000, 32'h8000_0000, 2'd1, 4'd3, 64'hC000_0000_0000_0000);
    corner("m3_min",  32'h8000_0000, 32'h8000_0000, 2'd3, 4'd4, 64'h4000_0000_0000_0000);
    corner("m2_small", 32'd3, 32'hFFFF_FFFB, 2'd2, 4'd5, 64'hFFFF_FFFF_FFFF_FFF1);
    corner("m0_small", 32'd3, 32'hFFFF_FFFB, 2'd0, 4'd6, 64'h0000_0002_FFFF_FFF1);
    corner("m1_small", 32'hFFFF_FFFB, 32'd3, 2'd1, 4'd7, 64'hFFFF_FFFF_FFFF_FFF1);
    corner("m2_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd2, 4'd8, 64'hFFFF_FFFF_0000_0001);

    // Latency and throughput: eight back-to-back ops, results after edges 2..9.
    for (int c = 0; c < 12; c++) begin
      in_valid = (c < 8);
      in_tag   = 4'(c);
      a        = 32'(c + 1);
      b        = 32'(c + 2);
      mode     = 2'd0;
      @(posedge clk);
      #1;
      check("tp_valid", 128'(out_valid), 128'(c >= 2 && c <= 9));
      if (c >= 2 && c <= 9) begin
        check("tp_tag", 128'(out_tag), 128'(c - 2));
        check("tp_product", 128'(product), 128'((c - 1) * c));
      end
    end
    in_valid = 1'b0;

    // Backpressure: stall five cycles with a new op held at the input.
    out_ready = 1'b1;
    for (int t = 8; t <= 10; t++) begin
      drive_op(32'(t), 32'(t + 1), 2'd0, 4'(t));
      cycle();
    end
    drive_op(32'd11, 32'd12, 2'd0, 4'd11);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_in_ready", 128'(in_ready), 128'(0));
      check("bp_valid", 128'(out_valid), 128'(1));
      check("bp_tag", 128'(out_tag), 128'(8));
      check("bp_product", 128'(product), 128'(72));
      cycle();
    end
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    repeat (6) cycle();
    check("bp_drained", 128'(exp_q.size()), 128'(0));

    // Flush with three ops in flight and the oldest stalled at the output.
    for (int t = 1; t <= 3; t++) begin
      drive_op(32'(t + 20), 32'd3, 2'd3, 4'(t));
      cycle();
    end
    drive_op(32'd40, 32'd2, 2'd0, 4'd4);
    flush     = 1'b1;
    out_ready = 1'b0;
    #1;
    check("flush_in_ready", 128'(in_ready), 128'(0));
    cycle();
    flush = 1'b0;
    check("flush_out_valid", 128'(out_valid), 128'(0));
    check("flush_product", 128'(product), 128'(0));
    drive_op(32'd50, 32'd6, 2'd0, 4'd5);
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    repeat (5) cycle();
    check("flush_drained", 128'(exp_q.size()), 128'(0));

    // Asynchronous reset between edges while results are streaming.
    for (int t = 0; t < 4; t++) begin
      drive_op(32'(t + 100), 32'(t + 7), 2'd0, 4'(t));
      cycle();
    end
    check("arst_pre_valid", 128'(out_valid), 128'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 128'(out_valid), 128'(0));
    check("arst_product", 128'(product), 128'(0));
    check("arst_out_tag", 128'(out_tag), 128'(0));
    exp_q.delete();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) cycle();
    check("arst_post_valid", 128'(out_valid), 128'(0));

    // Random traffic on the main instance.
    for (int c = 0; c < 300; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      a         = pick32();
      b         = pick32();
      mode      = 2'($urandom_range(0, 3));
      in_tag    = 4'(c);
      cycle();
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (8) cycle();
    check("rand_drained", 128'(exp_q.size()), 128'(0));

    for (int i = 0; i < 2000 && done_cnt < 3; i++) @(posedge clk);
    check("rand_configs_done", 128'(done_cnt), 128'(3));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Further widths and depths under random traffic, each with its own scoreboard.
  for (genvar g = 0; g < 3; g++) begin : g_rnd
    localparam int W = (g == 0) ? 8 : (g == 1) ? 17 : 64;
    localparam int S = (g == 1) ? 2 : 6;
    logic           fl;
    logic           iv;
    logic           ir;
    logic           ov;
    logic           ordy;
    logic [W-1:0]   ga;
    logic [W-1:0]   gb;
    logic [1:0]     gm;
    logic [3:0]     gti;
    logic [3:0]     gto;
    logic [2*W-1:0] gp;
    exp_t           gq[$];

    pipelined_wallace_multiplier #(.WIDTH(W), .STAGES(S), .TAG_W(4)) u_rnd (
      .clk       (clk),
      .rst_n     (rst_x),
      .flush     (fl),
      .in_valid  (iv),
      .in_ready  (ir),
      .a         (ga),
      .b         (gb),
      .mode      (gm),
      .in_tag    (gti),
      .out_valid (ov),
      .out_ready (ordy),
      .product   (gp),
      .out_tag   (gto)
    );

    initial begin
      exp_t e;
      fl = 1'b0; iv = 1'b0; ordy = 1'b1; ga = '0; gb = '0; gm = '0; gti = '0;
      wait (rst_x === 1'b1);
      @(posedge clk);
      #1;
      for (int c = 0; c < 420; c++) begin
        if (c < 400) begin
          iv   = ($urandom_range(0, 3) != 0);
          ordy = ($urandom_range(0, 3) != 0);
          fl   = ($urandom_range(0, 50) == 0);
          case ($urandom_range(0, 5))
            0:       ga = '0;
            1:       ga = '1;
            2:       begin ga = '0; ga[W-1] = 1'b1; end
            default: ga = W'({$urandom, $urandom});
          endcase
          case ($urandom_range(0, 5))
            0:       gb = '0;
            1:       gb = '1;
            2:       begin gb = '0; gb[W-1] = 1'b1; end
            default: gb = W'({$urandom, $urandom});
          endcase
          gm  = 2'($urandom_range(0, 3));
          gti = 4'(c);
        end else begin
          iv   = 1'b0;
          fl   = 1'b0;
          ordy = 1'b1;
        end
        #1;
        if (ov && ordy) begin
          check($sformatf("w%0d_out_expected", W), 128'(gq.size() != 0), 128'(1));
          if (gq.size() != 0) begin
            e = gq.pop_front();
            check($sformatf("w%0d_tag", W), 128'(gto), 128'(e.tag));
            check($sformatf("w%0d_product", W), 128'(gp), e.prod);
          end
        end
        if (iv && ir) begin
          e.tag  = gti;
          e.prod = ref_mul(64'(ga), 64'(gb), W, gm);
          gq.push_back(e);
        end
        if (fl) gq.delete();
        @(posedge clk);
        #1;
      end
      check($sformatf("w%0d_drained", W), 128'(gq.size()), 128'(0));
      done_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
